i_buf_controller: RTL and testbench

- Video capture front end; the input-side counterpart of the linebuffer-to-video output path.
- Samples a raw 8-bit pixel stream (pixel data plus vsync, hsync and vde) and packs 4 pixels into each 32-bit linebuffer word.
- Writes completed lines into a two-bank (ping-pong) linebuffer, then signals the Processing System (PS) to copy each finished line to the framebuffer.
- Flow control is line-level: the PS acknowledges each drained bank. A line arriving with no free bank is dropped and flagged.

---
 rtl/i_buf_controller_if.sv | 39 +++
 rtl/i_buf_controller.sv | 171 +++++++++++++++++
 tb/tb_i_buf_controller.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i_buf_controller_if.sv
// Video capture bus: raw pixel stream and PS line handshake in, linebuffer write port and status out.
// Option: CAPTURE_DROP_COUNT_EN adds the dropped_lines counter.
interface i_buf_controller_if #(
   parameter int ADDRESS_WIDTH = 32
);
   logic                     vsync;
   logic                     hsync;
   logic                     vde;
   logic [7:0]               i_data;
   logic                     line_ack;
   logic [ADDRESS_WIDTH-1:0] addr;
   logic [31:0]              o_data;
   logic                     wr_en;
   logic                     line_done;
   logic                     line_bank;
   logic                     frame_done;
   logic [12:0]              line_count;
   logic                     overflow;
`ifdef CAPTURE_DROP_COUNT_EN
   logic [15:0]              dropped_lines;
`endif

   // master: the capture controller; slave: video source, PS and linebuffer side
   modport master (
      input  vsync, hsync, vde, i_data, line_ack,
      output addr, o_data, wr_en, line_done, line_bank, frame_done, line_count, overflow
`ifdef CAPTURE_DROP_COUNT_EN
      , output dropped_lines
`endif
   );

   modport slave (
      output vsync, hsync, vde, i_data, line_ack,
      input  addr, o_data, wr_en, line_done, line_bank, frame_done, line_count, overflow
`ifdef CAPTURE_DROP_COUNT_EN
      , input dropped_lines
`endif
   );
endinterface

// File: rtl/i_buf_controller.sv
// Packs a raw 8-bit pixel stream into 32-bit words in a ping-pong linebuffer, with line-level PS handshake.
// Option: CAPTURE_DROP_COUNT_EN adds a saturating per-frame dropped_lines count.
module i_buf_controller #(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int DISPLAY_WIDTH  = 640,
   parameter int DISPLAY_HEIGHT = 480
) (
   input  logic               pclk,
   input  logic               reset_n,
   i_buf_controller_if.master bus
);
   localparam int WORDS_PER_LINE = DISPLAY_WIDTH / 4;
   localparam int PCW            = $clog2(DISPLAY_WIDTH + 1);

   typedef enum logic [2:0] {IDLE, WAIT_LINE, CAPTURE, FLUSH, DROP} state_t;

   state_t                   state, state_nxt;
   logic                     vsync_q, vsync_d, vde_q, vde_d, ack_q;
   logic [7:0]               data_q;
   logic [PCW-1:0]           pix_cnt, pix_base, wr_idx;
   logic [31:0]              acc, acc_nxt;
   logic [1:0]               lane;
   logic                     in_range;
   logic                     wr_bank, rd_bank;
   logic [1:0]               bank_full;
   logic [ADDRESS_WIDTH-1:0] bank_base;
   logic                     vsync_rise, vde_rise, vde_fall, sync_lost, frame_last;
   logic                     frame_start, px_take, drop_start, drop_end, flush_wr, line_end, line_abort;
   logic [ADDRESS_WIDTH-1:0] addr_r;
   logic [31:0]              o_data_r;
   logic                     wr_en_r, line_done_r, line_bank_r, frame_done_r, overflow_r;
   logic [12:0]              line_count_r;
   logic [15:0]              drop_cnt;

   // vsync is active low, so its idle level is the reset value: no false rise after reset
   always_ff @(posedge pclk) begin
      if (!reset_n) begin
         vsync_q <= 1'b1;
         vsync_d <= 1'b1;
         vde_q   <= 1'b0;
         vde_d   <= 1'b0;
         data_q  <= 8'h00;
         ack_q   <= 1'b0;
      end else begin
         vsync_q <= bus.vsync;
         vsync_d <= vsync_q;
         vde_q   <= bus.vde;
         vde_d   <= vde_q;
         data_q  <= bus.i_data;
         ack_q   <= bus.line_ack;
      end
   end

   assign vsync_rise = vsync_q & ~vsync_d;
   assign vde_rise   = vde_q & ~vde_d;
   assign vde_fall   = ~vde_q & vde_d;
   assign sync_lost  = ~vsync_q && (state != IDLE);
   assign frame_last = (line_count_r == 13'(DISPLAY_HEIGHT - 1));

   always_ff @(posedge pclk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (vsync_rise) state_nxt = WAIT_LINE;
         WAIT_LINE: if (vde_rise) state_nxt = bank_full[wr_bank] ? DROP : CAPTURE;
         CAPTURE:   if (vde_fall) state_nxt = FLUSH;
         FLUSH:     if (pix_cnt[1:0] == 2'd0) state_nxt = frame_last ? IDLE : WAIT_LINE;
         DROP:      if (vde_fall) state_nxt = frame_last ? IDLE : WAIT_LINE;
         default:   state_nxt = IDLE;
      endcase
      if (sync_lost) state_nxt = IDLE;
   end

   always_comb begin
      frame_start = (state == IDLE) && vsync_rise;
      px_take     = !sync_lost && vde_q &&
                    (((state == WAIT_LINE) && vde_rise && !bank_full[wr_bank]) || (state == CAPTURE));
      drop_start  = !sync_lost && (state == WAIT_LINE) && vde_rise && bank_full[wr_bank];
      drop_end    = !sync_lost && (state == DROP) && vde_fall;
      flush_wr    = !sync_lost && (state == FLUSH) && (pix_cnt[1:0] != 2'd0);
      line_end    = !sync_lost && (state == FLUSH) && (pix_cnt[1:0] == 2'd0);
      line_abort  = sync_lost && ((state == CAPTURE) || (state == FLUSH));
   end

   // The first pixel of a line is taken in WAIT_LINE, so the count restarts there
   assign pix_base  = (state == WAIT_LINE) ? '0 : pix_cnt;
   assign lane      = pix_base[1:0];
   assign in_range  = pix_base < PCW'(DISPLAY_WIDTH);
   assign acc_nxt   = (lane == 2'd0) ? {data_q, 24'h0} : (acc | ({data_q, 24'h0} >> {lane, 3'b000}));
   assign bank_base = wr_bank ? ADDRESS_WIDTH'(WORDS_PER_LINE) : '0;
   assign wr_idx    = flush_wr ? pix_cnt : pix_base;

   always_ff @(posedge pclk) begin
      if (!reset_n) begin
         pix_cnt      <= '0;
         acc          <= '0;
         addr_r       <= '0;
         o_data_r     <= '0;
         wr_en_r      <= 1'b0;
         line_done_r  <= 1'b0;
         line_bank_r  <= 1'b0;
         frame_done_r <= 1'b0;
         line_count_r <= '0;
         overflow_r   <= 1'b0;
         wr_bank      <= 1'b0;
         rd_bank      <= 1'b0;
         bank_full    <= 2'b00;
         drop_cnt     <= '0;
      end else begin
         wr_en_r      <= 1'b0;
         line_done_r  <= 1'b0;
         frame_done_r <= 1'b0;
         if (px_take) begin
            if (in_range) begin
               acc     <= acc_nxt;
               pix_cnt <= pix_base + 1'b1;
               if (lane == 2'd3) begin
                  wr_en_r  <= 1'b1;
                  o_data_r <= acc_nxt;
                  addr_r   <= bank_base + ADDRESS_WIDTH'(wr_idx >> 2);
               end
            end else begin
               overflow_r <= 1'b1;
            end
         end
         if (flush_wr) begin
            wr_en_r  <= 1'b1;
            o_data_r <= acc;
            addr_r   <= bank_base + ADDRESS_WIDTH'(wr_idx >> 2);
            pix_cnt  <= '0;
         end
         if (drop_start) overflow_r <= 1'b1;
         if (line_end || drop_end) begin
            line_count_r <= line_count_r + 13'd1;
            frame_done_r <= frame_last;
         end
         if (frame_start) line_count_r <= '0;
         if (ack_q && bank_full[rd_bank]) begin
            bank_full[rd_bank] <= 1'b0;
            rd_bank            <= ~rd_bank;
         end
         // A completing line outranks a same-bank ack; that ack found the bank empty anyway
         if (line_end) begin
            line_done_r        <= 1'b1;
            line_bank_r        <= wr_bank;
            bank_full[wr_bank] <= 1'b1;
            wr_bank            <= ~wr_bank;
         end
         if (frame_start)
            drop_cnt <= '0;
         else if ((drop_start || line_abort) && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
      end
   end

   assign bus.addr       = addr_r;
   assign bus.o_data     = o_data_r;
   assign bus.wr_en      = wr_en_r;
   assign bus.line_done  = line_done_r;
   assign bus.line_bank  = line_bank_r;
   assign bus.frame_done = frame_done_r;
   assign bus.line_count = line_count_r;
   assign bus.overflow   = overflow_r;
`ifdef CAPTURE_DROP_COUNT_EN
   assign bus.dropped_lines = drop_cnt;
`endif
endmodule

// File: tb/tb_i_buf_controller.sv
// Directed bench for i_buf_controller (8-pixel lines, 4-line frames) with an event scoreboard.
module tb_i_buf_controller;
   localparam int W = 8;
   localparam int H = 4;
   localparam logic [1:0] EV_NONE = 2'd0, EV_WR = 2'd1, EV_DONE = 2'd2;

   typedef struct {
      logic [1:0]  kind;
      logic [31:0] addr;
      logic [31:0] data;
      logic        bank;
      logic [12:0] lc;
      logic        fd;
   } ev_t;

   logic pclk;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   ev_t  sb[$];

   // reference model of bank ownership and frame progress
   logic       m_wr, m_rd, m_in, m_ovf;
   logic [1:0] m_full;
   int         m_lc, m_drop;

   i_buf_controller_if #(.ADDRESS_WIDTH(32)) bus ();

   i_buf_controller #(.ADDRESS_WIDTH(32), .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H)) dut (
      .pclk    (pclk),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   function automatic ev_t pop_ev();
      ev_t e;
      e.kind = EV_NONE; e.addr = '0; e.data = '0; e.bank = 1'b0; e.lc = '0; e.fd = 1'b0;
      if (sb.size() != 0) e = sb.pop_front();
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic mon();
      ev_t e;
      if (bus.wr_en === 1'b1) begin
         e = pop_ev();
         checks++;
         assert ({e.kind, bus.addr, bus.o_data} === {EV_WR, e.addr, e.data}) else begin
            errors++;
            $error("FAIL wr_word: got addr=%0h data=%08h, expected kind=%0d addr=%0h data=%08h",
                   bus.addr, bus.o_data, e.kind, e.addr, e.data);
         end
      end
      if (bus.line_done === 1'b1 || bus.frame_done === 1'b1) begin
         e = pop_ev();
         checks++;
         assert ({e.kind, bus.line_done, bus.line_bank, bus.line_count, bus.frame_done} ===
                 {EV_DONE, 1'b1, e.bank, e.lc, e.fd}) else begin
            errors++;
            $error("FAIL line_done: got done=%b bank=%b count=%0d frame=%b, expected kind=%0d bank=%b count=%0d frame=%b",
                   bus.line_done, bus.line_bank, bus.line_count, bus.frame_done, e.kind, e.bank, e.lc, e.fd);
         end
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
      mon();
   endtask

   task automatic model_reset();
      m_wr = 1'b0; m_rd = 1'b0; m_in = 1'b0; m_ovf = 1'b0; m_full = 2'b00; m_lc = 0; m_drop = 0;
   endtask

   task automatic model_line(input logic [7:0] first, input int n);
      int nk;
      ev_t e;
      logic [31:0] d;
      if (!m_in) return;
      if (m_full[m_wr]) begin
         m_ovf = 1'b1;
         if (m_drop < 65535) m_drop++;
         m_lc++;
         if (m_lc == H) m_in = 1'b0;
         return;
      end
      if (n > W) m_ovf = 1'b1;
      nk = (n > W) ? W : n;
      for (int w = 0; w < (nk + 3) / 4; w++) begin
         d = '0;
         for (int b = 0; b < 4; b++)
            if (4 * w + b < nk) d[31 - 8 * b -: 8] = 8'(first + 8'(4 * w + b));
         e.kind = EV_WR; e.addr = 32'(int'(m_wr) * (W / 4) + w); e.data = d;
         e.bank = m_wr; e.lc = '0; e.fd = 1'b0;
         sb.push_back(e);
      end
      m_lc++;
      e.kind = EV_DONE; e.addr = '0; e.data = '0; e.bank = m_wr; e.lc = 13'(m_lc); e.fd = (m_lc == H);
      sb.push_back(e);
      m_full[m_wr] = 1'b1;
      m_wr = ~m_wr;
      if (m_lc == H) m_in = 1'b0;
   endtask

   task automatic send_line(input logic [7:0] first, input int n);
      model_line(first, n);
      for (int i = 0; i < n; i++) begin
         bus.vde = 1'b1;
         bus.i_data = 8'(first + 8'(i));
         step();
      end
      bus.vde = 1'b0;
      bus.i_data = 8'h00;
      repeat (6) step();
      chk("events_drained", 64'(sb.size()), 64'd0);
   endtask

   task automatic do_ack();
      bus.line_ack = 1'b1;
      step();
      bus.line_ack = 1'b0;
      if (m_full[m_rd]) begin
         m_full[m_rd] = 1'b0;
         m_rd = ~m_rd;
      end
      repeat (3) step();
   endtask

   task automatic vsync_pulse();
      bus.vsync = 1'b0;
      repeat (3) step();
      bus.vsync = 1'b1;
      m_lc = 0; m_in = 1'b1; m_drop = 0;
      repeat (3) step();
      chk("line_count_frame_start", 64'(bus.line_count), 64'd0);
   endtask

   task automatic chk_drop();
`ifdef CAPTURE_DROP_COUNT_EN
      chk("dropped_lines", 64'(bus.dropped_lines), 64'(m_drop));
`endif
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk(tag, 64'({bus.addr, bus.wr_en, bus.line_done, bus.line_bank, bus.frame_done, bus.line_count, bus.overflow}), 64'd0);
      chk({tag, "_data"}, 64'(bus.o_data), 64'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      bus.vsync = 1'b1; bus.hsync = 1'b1; bus.vde = 1'b0; bus.i_data = 8'h00; bus.line_ack = 1'b0;
      model_reset();
      repeat (3) step();
      chk_outputs_zero("reset_state");
      reset_n = 1'b1;
      repeat (2) step();
      chk_outputs_zero("post_reset_idle");

      // frame 1: full line, partial line, overlong line, last line, then ignored burst
      vsync_pulse();
      send_line(8'h01, 8);
      chk("line_count_after_1", 64'(bus.line_count), 64'd1);
      do_ack();
      send_line(8'hA0, 6);
      chk("short_line_no_overflow", 64'(bus.overflow), 64'd0);
      do_ack();
      send_line(8'h10, 9);
      chk("overlong_overflow", 64'(bus.overflow), 64'(m_ovf));
      send_line(8'h40, 8);
      send_line(8'h50, 4);
      chk("line_count_held_after_frame", 64'(bus.line_count), 64'd4);
      do_ack();
      do_ack();

      // frame 2: third line with both banks full is dropped
      vsync_pulse();
      send_line(8'h60, 8);
      send_line(8'h70, 8);
      send_line(8'h80, 8);
      chk("drop_overflow", 64'(bus.overflow), 64'd1);
      chk("drop_line_count", 64'(bus.line_count), 64'd3);
      chk_drop();
      do_ack();
      send_line(8'h90, 8);
      do_ack();
      do_ack();

      // frame 3: sync loss after 3 pixels, 4th pixel arrives with vsync low
      vsync_pulse();
      for (int i = 0; i < 3; i++) begin
         bus.vde = 1'b1;
         bus.i_data = 8'(8'hC0 + 8'(i));
         step();
      end
      bus.vsync = 1'b0;
      bus.i_data = 8'hC3;
      step();
      bus.vde = 1'b0;
      m_in = 1'b0;
      if (m_drop < 65535) m_drop++;
      repeat (4) step();
      send_line(8'hE0, 4);
      chk_drop();
      vsync_pulse();
      send_line(8'hB0, 8);

      // reset in the middle of a captured line
      for (int i = 0; i < 2; i++) begin
         bus.vde = 1'b1;
         bus.i_data = 8'(8'hD0 + 8'(i));
         step();
      end
      reset_n = 1'b0;
      step();
      chk_outputs_zero("mid_line_reset");
      model_reset();
      reset_n = 1'b1;
      bus.vde = 1'b0;
      repeat (3) step();
      chk_drop();

      // ack with both banks empty must be ignored
      do_ack();
      vsync_pulse();
      send_line(8'h01, 8);
      send_line(8'h21, 8);
      do_ack();
      send_line(8'h31, 4);
      chk("final_line_count", 64'(bus.line_count), 64'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
